// File: rtl/mem_port_arbiter.sv
// Three-port arbiter/sequencer for a single-port synchronous data memory with one-cycle registered read.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority port1 > port2 > port0.
module mem_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          req2,
    input  logic          we2,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata2,
    output logic          ack0,
    output logic          ack1,
    output logic          ack2,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [1:0]    gnt_id,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          grant;
    logic          any_req;
    logic [1:0]    win;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_we;

    assign any_req = req0 | req1 | req2;

`ifdef MEM_ARB_RR_EN
    // Pointer to the last winner; the search begins one port past it.
    logic [1:0] last_ptr;

    always_comb begin
        win = 2'd0;
        case (last_ptr)
            2'd0:    win = req1 ? 2'd1 : (req2 ? 2'd2 : 2'd0);
            2'd1:    win = req2 ? 2'd2 : (req0 ? 2'd0 : 2'd1);
            default: win = req0 ? 2'd0 : (req1 ? 2'd1 : 2'd2);
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_ptr <= 2'd2;
        end else if (grant) begin
            last_ptr <= win;
        end
    end
`else
    always_comb begin
        win = req1 ? 2'd1 : (req2 ? 2'd2 : 2'd0);
    end
`endif

    always_comb begin
        sel_addr = addr0;
        sel_data = '0;
        sel_we   = 1'b0;
        case (win)
            2'd1: begin
                sel_addr = addr1;
                sel_data = wdata1;
                sel_we   = we1;
            end
            2'd2: begin
                sel_addr = addr2;
                sel_data = wdata2;
                sel_we   = we2;
            end
            default: ;
        endcase
    end

    // RESP arbitrates again so back-to-back traffic never passes through IDLE.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                    grant      = 1'b1;
                end
            end
            ISSUE: state_next = RESP;
            RESP: begin
                if (any_req) begin
                    state_next = ISSUE;
                    grant      = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            gnt_id   <= 2'd0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                gnt_id   <= win;
                mem_addr <= sel_addr;
                mem_data <= sel_data;
                mem_wren <= sel_we;
            end else begin
                mem_wren <= 1'b0;
            end
        end
    end

    // Acks decode from registered state only, so a request never reaches an output combinationally.
    assign ack0      = (state == RESP) && (gnt_id == 2'd0);
    assign ack1      = (state == RESP) && (gnt_id == 2'd1);
    assign ack2      = (state == RESP) && (gnt_id == 2'd2);
    assign rdata     = mem_q;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table-driven single accesses plus contention, starvation and reset-in-flight sequences.
module tb_mem_port_arbiter;

    localparam int W = 19;  // {is_write, port[1:0], rdata[15:0]}

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
    logic        we1 = 1'b0, we2 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0, addr2 = '0;
    logic [15:0] wdata1 = '0, wdata2 = '0;
    logic        ack0, ack1, ack2, busy, mem_wren;
    logic [15:0] rdata, mem_data, mem_q;
    logic [1:0]  gnt_id, dbg_state;
    logic [7:0]  mem_addr;

    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic [15:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wren_cnt = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        int          port;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    mem_port_arbiter #(.AW(8), .DW(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .req0(req0), .addr0(addr0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .req2(req2), .we2(we2), .addr2(addr2), .wdata2(wdata2),
        .ack0(ack0), .ack1(ack1), .ack2(ack2),
        .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .dbg_state(dbg_state)
    );

    // Clock / reset block and memory model
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    always @(posedge Clock) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (mem_wren) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? ack0 : ((p == 1) ? ack1 : ack2);
    endfunction

    // Scoreboard: every ack pops one expected entry
    always @(negedge Clock) begin
        int n_ack;
        logic [1:0] port;
        logic [W-1:0] e;
        if (mem_wren) wren_cnt++;
        n_ack = int'(ack0) + int'(ack1) + int'(ack2);
        if (n_ack > 1) begin
            check("multi_ack", n_ack, 1);
        end else if (n_ack == 1) begin
            port = ack0 ? 2'd0 : (ack1 ? 2'd1 : 2'd2);
            if (exp_q.size() == 0) begin
                check("unexpected_ack_port", {30'd0, port}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", {30'd0, port}, {30'd0, e[17:16]});
                if (!e[18]) check("ack_rdata", {16'd0, rdata}, {16'd0, e[15:0]});
            end
        end
    end

    // Driver tasks
    task automatic mem_load(input logic [7:0] a, input logic [15:0] d);
        @(negedge Clock);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge Clock);
        load_en = 1'b0;
    endtask

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [7:0] a, input logic [15:0] d);
        case (p)
            0: begin req0 = v; addr0 = a; end
            1: begin req1 = v; we1 = we; addr1 = a; wdata1 = d; end
            default: begin req2 = v; we2 = we; addr2 = a; wdata2 = d; end
        endcase
    endtask

    task automatic do_access(input vec_t v, input string tag);
        int waited;
        bit done;
        @(negedge Clock);
        check({tag, "_idle_busy"}, busy, 0);
        wren_cnt = 0;
        exp_q.push_back({v.we, 2'(v.port), v.exp_rdata});
        set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
        waited = 0;
        done = 0;
        while (!done && waited < 20) begin
            @(negedge Clock);
            waited++;
            if (waited == 1) begin
                check({tag, "_issue_busy"}, busy, 1);
                // Scramble the held inputs: the grant already latched them.
                set_req(v.port, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
            end
            if (ack_of(v.port)) begin
                done = 1;
                check({tag, "_gnt_id"}, gnt_id, v.port);
                check({tag, "_resp_busy"}, busy, 1);
                set_req(v.port, 1'b0, 1'b0, 8'h00, 16'h0000);
            end
        end
        check({tag, "_acked"}, done, 1);
        check({tag, "_latency"}, waited, 2);
        check({tag, "_wren_cycles"}, wren_cnt, v.we ? 1 : 0);
    endtask

    // Holds the given ports until each collects n_each acks; checks 2-cycle spacing between consecutive acks.
    task automatic hold_ports(input logic [2:0] ports, input int n_each, input string tag);
        int cnt[3];
        int last_t;
        int guard;
        bit first;
        cnt = '{0, 0, 0};
        first = 1;
        last_t = 0;
        guard = 0;
        while ((req0 | req1 | req2) && guard < 60) begin
            @(negedge Clock);
            guard++;
            check({tag, "_busy"}, busy, 1);
            for (int p = 0; p < 3; p++) begin
                if (ports[p] && ack_of(p)) begin
                    if (!first) check({tag, "_spacing"}, cyc - last_t, 2);
                    if (first) check({tag, "_first_latency"}, guard, 2);
                    first = 0;
                    last_t = cyc;
                    cnt[p]++;
                    if (cnt[p] == n_each) set_req(p, 1'b0, 1'b0, 8'h00, 16'h0000);
                end
            end
        end
        check({tag, "_done"}, (req0 | req1 | req2), 0);
    endtask

    initial begin
        vecs[0]  = '{0, 1'b0, 8'h12, 16'h0000, 16'hBEEF};
        vecs[1]  = '{1, 1'b1, 8'h05, 16'h1234, 16'h0000};
        vecs[2]  = '{1, 1'b0, 8'h05, 16'h0000, 16'h1234};
        vecs[3]  = '{2, 1'b1, 8'h40, 16'hCAFE, 16'h0000};
        vecs[4]  = '{0, 1'b0, 8'h40, 16'h0000, 16'hCAFE};
        vecs[5]  = '{2, 1'b0, 8'h05, 16'h0000, 16'h1234};
        vecs[6]  = '{1, 1'b1, 8'h05, 16'h5678, 16'h0000};
        vecs[7]  = '{2, 1'b0, 8'h05, 16'h0000, 16'h5678};
        vecs[8]  = '{2, 1'b1, 8'hFF, 16'hFFFF, 16'h0000};
        vecs[9]  = '{1, 1'b0, 8'hFF, 16'h0000, 16'hFFFF};
        vecs[10] = '{0, 1'b0, 8'h00, 16'h0000, 16'h0000};

        // Preload memory while the arbiter is held in reset
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem_load(8'h12, 16'hBEEF);
        mem_load(8'h30, 16'h3001);
        mem_load(8'h31, 16'h3102);
        mem_load(8'h32, 16'h3200);
        @(negedge Clock);
        Reset = 1'b0;

        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_ack2", ack2, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_mem_wren", mem_wren, 0);
        check("rst_state", dbg_state, 0);

`ifdef MEM_ARB_RR_EN
        // Round robin from reset: 0,1,2,0,1,2 with all three held
        @(negedge Clock);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back({1'b0, 2'd0, 16'h3200});
            exp_q.push_back({1'b0, 2'd1, 16'h3001});
            exp_q.push_back({1'b0, 2'd2, 16'h3102});
        end
        set_req(0, 1'b1, 1'b0, 8'h32, 16'h0000);
        set_req(1, 1'b1, 1'b0, 8'h30, 16'h0000);
        set_req(2, 1'b1, 1'b0, 8'h31, 16'h0000);
        hold_ports(3'b111, 2, "rr");
`endif

        for (int i = 0; i < 11; i++) do_access(vecs[i], $sformatf("vec%0d", i));

`ifndef MEM_ARB_RR_EN
        // Fixed-priority contention: order 1, 2, 0 back to back
        @(negedge Clock);
        exp_q.push_back({1'b0, 2'd1, 16'h3001});
        exp_q.push_back({1'b0, 2'd2, 16'h3102});
        exp_q.push_back({1'b0, 2'd0, 16'h3200});
        set_req(0, 1'b1, 1'b0, 8'h32, 16'h0000);
        set_req(1, 1'b1, 1'b0, 8'h30, 16'h0000);
        set_req(2, 1'b1, 1'b0, 8'h31, 16'h0000);
        hold_ports(3'b111, 1, "contend");

        // Starvation: port1 held for five grants locks port0 out until it drops
        @(negedge Clock);
        repeat (5) exp_q.push_back({1'b0, 2'd1, 16'h3001});
        set_req(0, 1'b1, 1'b0, 8'h12, 16'h0000);
        set_req(1, 1'b1, 1'b0, 8'h30, 16'h0000);
        begin
            int n1, t1, guard;
            n1 = 0; t1 = 0; guard = 0;
            while (n1 < 5 && guard < 40) begin
                @(negedge Clock);
                guard++;
                if (ack1) begin
                    n1++;
                    t1 = cyc;
                    if (n1 == 5) begin
                        set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
                        exp_q.push_back({1'b0, 2'd0, 16'hBEEF});
                    end
                end
            end
            check("starve_ack1_count", n1, 5);
            guard = 0;
            while (!ack0 && guard < 10) begin
                @(negedge Clock);
                guard++;
            end
            check("starve_ack0_seen", ack0, 1);
            check("starve_ack0_delay", cyc - t1, 2);
            set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        end
`endif

        // Reset during ISSUE of a port2 write: write lands, no ack
        @(negedge Clock);
        @(negedge Clock);
        set_req(2, 1'b1, 1'b1, 8'h20, 16'hA5A5);
        @(negedge Clock);
        check("rst_mid_issue_wren", mem_wren, 1);
        Reset = 1'b1;
        set_req(2, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge Clock);
        Reset = 1'b0;
        check("rst_mid_state", dbg_state, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wren", mem_wren, 0);
        repeat (3) begin
            @(negedge Clock);
            check("rst_mid_no_ack2", ack2, 0);
        end
        do_access('{0, 1'b0, 8'h20, 16'h0000, 16'hA5A5}, "rst_readback");

        repeat (3) @(negedge Clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Three-requester arbiter and sequencer for the single-port synchronous main data memory (8-bit address, 16-bit data, one-cycle registered read). It sits between the processor's fetch path, the processor's load/store path, and a debug/loader port. It grants one access at a time, drives the memory address, write-data and write-enable from registers, and returns read data with a per-port acknowledge.

## Interface
Parameters:
- AW, 8: memory address width.
- DW, 16: memory data width.

Ports:
- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0  in  1  fetch request (read-only port).
- addr0  in  AW  fetch address.
- req1 / we1  in  1 / 1  load/store request; we1=1 means write.
- addr1 / wdata1  in  AW / DW  load/store address and write data.
- req2 / we2  in  1 / 1  debug/loader request and write flag.
- addr2 / wdata2  in  AW / DW  debug address and write data.
- ack0, ack1, ack2  out  1  one-cycle completion pulse per port.
- rdata  out  DW  read data, shared by all ports; valid only while an ack is high.
- busy  out  1  high when state is not IDLE.
- gnt_id  out  2  port currently or last granted (0/1/2).
- mem_addr  out  AW  registered memory address.
- mem_data  out  DW  registered memory write data.
- mem_wren  out  1  registered memory write enable.
- mem_q  in  DW  memory read data, valid the cycle after the address is presented.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any reqN=1, select a winner, latch its addr, wdata and we (port 0 has we=0) into mem_addr, mem_data and mem_wren, set gnt_id, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: the memory samples mem_addr, mem_data and mem_wren at the end of this cycle. Always go to RESP.
- RESP:
  - mem_wren=0.
  - ack[gnt_id]=1; rdata=mem_q.
  - If any reqN=1, arbitrate again, latch the winner, and go to ISSUE. Otherwise go to IDLE.
- A requester holds req until it sees its ack. A req still high at the ack edge is treated as a new request.
- Address, data and we are latched at grant. They may change after the grant edge.
- For writes, ack still pulses and rdata content is don't-care.
- Winner selection is fixed priority: port1 > port2 > port0. See Configuration for the alternative.
- mem_wren is high only during ISSUE of a write. It is never high in IDLE or RESP.

## Timing
- Reset values: state=IDLE, ack0..2=0, busy=0, gnt_id=0, mem_addr=0, mem_data=0, mem_wren=0. rdata follows mem_q and is don't-care without an ack.
- Latency from request to ack:
  - req seen at edge k (IDLE) → ISSUE in cycle k+1 → ack in cycle k+2.
  - Read data is valid in the same cycle as the ack.
- Throughput: one access per 2 cycles when requests are back-to-back. There are no idle cycles between RESP and the next ISSUE.
- Simultaneous requests: exactly one ack per RESP. Losers wait with req held.
- Reset asserted during ISSUE:
  - The memory still samples that cycle's registered outputs, so a write in flight completes.
  - The FSM goes to IDLE and no ack is issued.
- Reset asserted during RESP: the ack for that cycle is still visible, because acks decode from registered state. Next state is IDLE.
- Acks and mem_* are decoded from registers only. There is no combinational path from reqN to any output.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration. The search starts at (last gnt_id + 1) mod 3 and wraps 2→0.
  - The last-grant pointer resets to 2, so port0 has first priority after reset.
  - No port waits more than 2 grants while its req is held.
- Not defined: fixed priority port1 > port2 > port0. Port0 can starve under continuous port1/port2 traffic.

## Test plan
- Single read: mem holds 0xBEEF at 0x12; pulse req0 with addr0=0x12 in IDLE → ack0 in cycle k+2 with rdata=0xBEEF; busy high for cycles k+1..k+2.
- Write then read: req1, we1=1, addr1=0x05, wdata1=0x1234 → mem_wren=1 for exactly one cycle; ack1. Then req1, we1=0 at 0x05 → rdata=0x1234.
- Contention, fixed priority: req0, req1 and req2 all high from one edge and held until own ack → ack order 1, 2, 0, each 2 cycles apart, with no IDLE state between grants.
- Contention with MEM_ARB_RR_EN: req0, req1 and req2 held continuously → after reset the grant sequence is 0, 1, 2, 0, 1, 2.
- Reset mid-write: assert Reset during ISSUE of a port2 write of 0xA5A5 to 0x20 → no ack2, FSM in IDLE, and a later read of 0x20 returns 0xA5A5.
- Starvation check without the macro: req1 held high, req0 held high → ack1 every 2 cycles and ack0 never asserted; drop req1 → ack0 follows within 2 cycles.
